rgb_wheel_pwm: RTL and testbench

Parametrised N-channel colour-wheel PWM generator: one shared timebase steps a 6-state hue sequence, and each channel follows the same ramp/hold duty profile at its own phase offset. It generalises the fixed 3-channel RGB controller with:
- parametrised channel count and per-channel phase offsets;
- run/pause and reverse direction;
- synchronous restart;
- global brightness scaling;
- selectable output polarity.

It sits between the board clock/reset and the LED pins.

---
 rtl/rgb_wheel_pwm_if.sv | 24 ++
 rtl/rgb_wheel_pwm.sv | 201 ++++++++++++++++++++
 tb/tb_rgb_wheel_pwm.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rgb_wheel_pwm_if.sv
// Control/status bundle for rgb_wheel_pwm: run/direction/restart/brightness in,
// per-channel PWM pins plus hue-sequence status (state, tick, wrap) out.
interface rgb_wheel_pwm_if #(
  parameter int N_CH = 3
);
  logic            run;
  logic            dir;
  logic            sync_clr;
  logic [7:0]      brightness;
  logic [N_CH-1:0] pwm_out;
  logic [2:0]      state;
  logic            tick;
  logic            wrap;

  modport master (
    output run, dir, sync_clr, brightness,
    input  pwm_out, state, tick, wrap
  );

  modport slave (
    input  run, dir, sync_clr, brightness,
    output pwm_out, state, tick, wrap
  );
endinterface

// File: rtl/rgb_wheel_pwm.sv
// N-channel colour-wheel PWM: shared prescaled timebase walks a 6-state hue sequence.
// Latency: duty/brightness to pin 2 cycles; state/wrap visible the cycle after tick; no backpressure.
module rgb_wheel_pwm #(
  parameter int          N_CH             = 3,
  parameter logic [23:0] CH_OFFSET        = 24'h000_014,
  parameter int          INC_DEC_INTERVAL = 10_000,
  parameter int          INC_DEC_MAX      = 200,
  parameter int          PWM_INTERVAL     = 1200,
  parameter int          STEP_VAL         = (PWM_INTERVAL / INC_DEC_MAX > 1) ?
                                            (PWM_INTERVAL / INC_DEC_MAX) : 1,
  parameter bit          OUT_ACTIVE_LOW   = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  rgb_wheel_pwm_if.slave bus
);

  localparam int PW = $clog2(INC_DEC_INTERVAL);
  localparam int TW = (INC_DEC_MAX > 1) ? $clog2(INC_DEC_MAX) : 1;
  localparam int DW = $clog2(PWM_INTERVAL + 1);
  localparam int CW = (PWM_INTERVAL > 1) ? $clog2(PWM_INTERVAL) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(INC_DEC_INTERVAL - 1);
  localparam logic [TW-1:0] TCNT_LAST  = TW'(INC_DEC_MAX - 1);
  localparam logic [CW-1:0] PCNT_LAST  = CW'(PWM_INTERVAL - 1);
  localparam logic [DW-1:0] DUTY_MAX   = DW'(PWM_INTERVAL);
  localparam logic [DW-1:0] STEP_D     = DW'(STEP_VAL);

  if (N_CH < 1 || N_CH > 8) begin : g_bad_nch
    $error("rgb_wheel_pwm: N_CH must be 1..8");
  end
  if (INC_DEC_INTERVAL < 2 || INC_DEC_MAX < 1) begin : g_bad_timebase
    $error("rgb_wheel_pwm: INC_DEC_INTERVAL must be >= 2 and INC_DEC_MAX >= 1");
  end

  typedef enum logic [2:0] {
    ST_0 = 3'd0,
    ST_1 = 3'd1,
    ST_2 = 3'd2,
    ST_3 = 3'd3,
    ST_4 = 3'd4,
    ST_5 = 3'd5
  } hue_t;

  logic [PW-1:0]   r_presc;
  logic            r_tick;
  logic [TW-1:0]   r_tcnt;
  hue_t            r_state;
  hue_t            w_state_nxt;
  logic            r_wrap;
  logic            w_wrap_nxt;
  logic            w_step;
  logic [CW-1:0]   r_pcnt;
  logic [N_CH-1:0] w_raw;

  // Prescaler holds while paused; tick is the registered wrap strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else if (bus.sync_clr) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (bus.run) begin
        if (r_presc == PRESC_LAST) begin
          r_presc <= '0;
          r_tick  <= 1'b1;
        end else begin
          r_presc <= r_presc + PW'(1);
        end
      end
    end
  end

  assign w_step = r_tick && (r_tcnt == TCNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tcnt <= '0;
    end else if (bus.sync_clr) begin
      r_tcnt <= '0;
    end else if (r_tick) begin
      r_tcnt <= (r_tcnt == TCNT_LAST) ? '0 : r_tcnt + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wrap_nxt  = 1'b0;
    if (bus.sync_clr) begin
      w_state_nxt = ST_0;
    end else if (w_step) begin
      if (bus.dir) begin
        if (r_state == ST_5) begin
          w_state_nxt = ST_0;
          w_wrap_nxt  = 1'b1;
        end else begin
          w_state_nxt = hue_t'(r_state + 3'd1);
        end
      end else begin
        if (r_state == ST_0) begin
          w_state_nxt = ST_5;
          w_wrap_nxt  = 1'b1;
        end else begin
          w_state_nxt = hue_t'(r_state - 3'd1);
        end
      end
    end
  end

  // PWM counter is never paused so pins keep toggling while the wheel is frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcnt <= '0;
    end else if (bus.sync_clr) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= (r_pcnt == PCNT_LAST) ? '0 : r_pcnt + CW'(1);
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    localparam logic [2:0]    OFF       = CH_OFFSET[3*gi +: 3];
    localparam logic [DW-1:0] DUTY_INIT = (OFF >= 3'd1 && OFF <= 3'd3) ? DUTY_MAX : '0;

    if (OFF > 3'd5) begin : g_bad_off
      $error("rgb_wheel_pwm: CH_OFFSET field must be < 6");
    end

    logic [3:0]    w_sum;
    logic [2:0]    w_phase;
    logic [DW-1:0] w_duty_up;
    logic [DW-1:0] w_duty_dn;
    logic [DW-1:0] w_duty_nxt;
    logic [DW+8:0] w_prod;
    logic [DW-1:0] w_scaled_nxt;
    logic [DW-1:0] r_duty;
    logic [DW-1:0] r_scaled;
    logic          r_raw;

    always_comb begin
      w_sum   = {1'b0, r_state} + {1'b0, OFF};
      w_phase = (w_sum >= 4'd6) ? 3'(w_sum - 4'd6) : w_sum[2:0];

      w_duty_up = (STEP_D >= DUTY_MAX || r_duty >= DUTY_MAX - STEP_D) ?
                  DUTY_MAX : r_duty + STEP_D;
      w_duty_dn = (r_duty <= STEP_D) ? '0 : r_duty - STEP_D;

      w_duty_nxt = r_duty;
      case (w_phase)
        3'd0:    w_duty_nxt = bus.dir ? w_duty_up : w_duty_dn;
        3'd3:    w_duty_nxt = bus.dir ? w_duty_dn : w_duty_up;
        3'd1,
        3'd2:    w_duty_nxt = DUTY_MAX;
        default: w_duty_nxt = '0;
      endcase

      // brightness+1 makes 255 an exact unity gain after the >>8.
      w_prod       = (DW+9)'(r_duty) * (DW+9)'({1'b0, bus.brightness} + 9'd1);
      w_scaled_nxt = DW'(w_prod >> 8);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_duty   <= DUTY_INIT;
        r_scaled <= '0;
        r_raw    <= 1'b0;
      end else if (bus.sync_clr) begin
        r_duty   <= DUTY_INIT;
        r_scaled <= '0;
        r_raw    <= (DW'(r_pcnt) < r_scaled);
      end else begin
        if (r_tick) begin
          r_duty <= w_duty_nxt;
        end
        r_scaled <= w_scaled_nxt;
        r_raw    <= (DW'(r_pcnt) < r_scaled);
      end
    end

    assign w_raw[gi] = r_raw;
  end

  assign bus.pwm_out = w_raw ^ {N_CH{OUT_ACTIVE_LOW}};
  assign bus.state   = r_state;
  assign bus.tick    = r_tick;
  assign bus.wrap    = r_wrap;

endmodule

// File: tb/tb_rgb_wheel_pwm.sv
// Directed-sequence bench with a cycle-level reference model of the colour wheel
// (tick = every 4th run cycle, state step every 5th tick, duty rules per phase).
module tb_rgb_wheel_pwm;
  localparam int NC   = 3;
  localparam int IVL  = 4;
  localparam int TMAX = 5;
  localparam int PWMI = 20;
  localparam int STEP = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rgb_wheel_pwm_if #(.N_CH(NC)) ifc ();

  rgb_wheel_pwm #(
    .N_CH(NC), .CH_OFFSET(24'h000_014), .INC_DEC_INTERVAL(IVL), .INC_DEC_MAX(TMAX),
    .PWM_INTERVAL(PWMI), .STEP_VAL(STEP), .OUT_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // reference model: values expected in the current cycle
  int off_tab[NC] = '{4, 2, 0};
  int m_runs, m_ticks, e_state, e_pcnt;
  bit e_tick, e_wrap;
  int e_duty[NC];
  int e_scaled[NC];
  logic [NC-1:0] e_raw;

  int seq[$];
  int last_st;
  int n_wrap;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_runs = 0; m_ticks = 0; e_state = 0; e_pcnt = 0;
    e_tick = 0; e_wrap = 0; e_raw = '0;
    for (int c = 0; c < NC; c++) begin
      e_scaled[c] = 0;
      e_duty[c]   = (off_tab[c] >= 1 && off_tab[c] <= 3) ? PWMI : 0;
    end
  endtask

  task automatic model_step();
    int n_scaled[NC];
    bit n_tick;
    for (int c = 0; c < NC; c++) begin
      e_raw[c]    = (e_pcnt < e_scaled[c]);
      n_scaled[c] = (e_duty[c] * (int'(ifc.brightness) + 1)) / 256;
    end
    if (ifc.sync_clr) begin
      e_pcnt = 0; e_state = 0; m_ticks = 0; m_runs = 0; e_tick = 0; e_wrap = 0;
      for (int c = 0; c < NC; c++) begin
        e_scaled[c] = 0;
        e_duty[c]   = (off_tab[c] >= 1 && off_tab[c] <= 3) ? PWMI : 0;
      end
    end else begin
      for (int c = 0; c < NC; c++) e_scaled[c] = n_scaled[c];
      e_pcnt = (e_pcnt + 1) % PWMI;
      n_tick = 0;
      if (ifc.run) begin
        m_runs++;
        n_tick = (m_runs % IVL == 0);
      end
      e_wrap = 0;
      if (e_tick) begin
        for (int c = 0; c < NC; c++) begin
          int p, up, dn;
          p  = (e_state + off_tab[c]) % 6;
          up = (e_duty[c] + STEP > PWMI) ? PWMI : e_duty[c] + STEP;
          dn = (e_duty[c] < STEP) ? 0 : e_duty[c] - STEP;
          if (p == 0)      e_duty[c] = ifc.dir ? up : dn;
          else if (p == 3) e_duty[c] = ifc.dir ? dn : up;
          else if (p <= 2) e_duty[c] = PWMI;
          else             e_duty[c] = 0;
        end
        m_ticks++;
        if (m_ticks % TMAX == 0) begin
          if (ifc.dir) begin
            e_wrap  = (e_state == 5);
            e_state = (e_state + 1) % 6;
          end else begin
            e_wrap  = (e_state == 0);
            e_state = (e_state + 5) % 6;
          end
        end
      end
      e_tick = n_tick;
    end
  endtask

  // one clock: model advances on posedge, DUT is compared at the following negedge
  task automatic cyc();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step();
    @(negedge clk);
    chk("state", ifc.state, e_state);
    chk("tick", ifc.tick, e_tick);
    chk("wrap", ifc.wrap, e_wrap);
    chk("pwm_out", ifc.pwm_out, e_raw ^ 3'b111);
    if (ifc.state !== 3'(last_st)) begin
      last_st = int'(ifc.state);
      seq.push_back(last_st);
    end
    if (ifc.wrap === 1'b1) n_wrap++;
  endtask

  task automatic restart_tracking();
    seq.delete();
    seq.push_back(0);
    last_st = 0;
    n_wrap  = 0;
  endtask

  function automatic int exp_seq(input int i);
    int tab[7] = '{0, 1, 2, 3, 4, 5, 0};
    return tab[i];
  endfunction

  initial begin
    int first_tick, tog, n_tick_p, gap, act;
    logic prev;
    bit found;

    ifc.run = 1'b1; ifc.dir = 1'b1; ifc.sync_clr = 1'b0; ifc.brightness = 8'd255;
    model_reset();
    restart_tracking();

    // reset state
    repeat (3) begin
      @(negedge clk);
      chk("rst_pwm", ifc.pwm_out, 3'b111);
      chk("rst_state", ifc.state, 0);
      chk("rst_tick", ifc.tick, 0);
      chk("rst_wrap", ifc.wrap, 0);
    end
    rst_n = 1'b1;
    model_reset();

    // forward run from reset: first tick on cycle 4, first step on cycle 21
    first_tick = -1;
    for (int k = 1; k <= 70; k++) begin
      cyc();
      if (ifc.tick === 1'b1 && first_tick < 0) first_tick = k;
      if (k == 20) chk("state_c20", ifc.state, 0);
      if (k == 21) chk("state_c21", ifc.state, 1);
    end
    chk("first_tick_cycle", first_tick, IVL);

    // pause mid-interval with channel 2 mid-ramp
    ifc.run = 1'b0;
    tog = 0; n_tick_p = 0; prev = ifc.pwm_out[2];
    repeat (50) begin
      cyc();
      if (ifc.tick === 1'b1) n_tick_p++;
      if (ifc.pwm_out[2] !== prev) tog++;
      prev = ifc.pwm_out[2];
    end
    chk("pause_ticks", n_tick_p, 0);
    chk("pause_state", ifc.state, 3);
    chk("pause_toggling", tog > 0, 1);

    ifc.run = 1'b1;
    gap = 0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      gap++;
      if (ifc.tick === 1'b1) break;
    end
    chk("resume_gap", gap, 2);

    found = 0;
    for (int k = 0; k < 200; k++) begin
      cyc();
      if (n_wrap > 0) begin found = 1; break; end
    end
    if (!found) begin
      n_cmp++; n_fail++;
      $error("FAIL fwd_wrap_timeout: observed no wrap, expected one within 200 cycles");
    end
    repeat (3) cyc();
    chk("fwd_wraps", n_wrap, 1);
    chk("fwd_seq_len", seq.size(), 7);
    for (int i = 0; i < 7 && i < seq.size(); i++) chk("fwd_seq", seq[i], exp_seq(i));

    // asynchronous reset mid-cycle, then reverse direction
    @(posedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_pwm", ifc.pwm_out, 3'b111);
    chk("arst_state", ifc.state, 0);
    chk("arst_tick", ifc.tick, 0);
    @(negedge clk);
    repeat (2) cyc();
    ifc.dir = 1'b0;
    rst_n = 1'b1;
    model_reset();
    restart_tracking();
    act = 0;
    for (int k = 1; k <= 24; k++) begin
      cyc();
      if (ifc.pwm_out[2] === 1'b0) act++;
      if (k == 21) chk("rev_state_c21", ifc.state, 5);
    end
    chk("rev_wraps", n_wrap, 1);
    chk("rev_ch2_active", act, 0);
    repeat (40) cyc();

    // brightness scaling on channel 1 (initial duty 20), wheel frozen
    rst_n = 1'b0;
    model_reset();
    repeat (2) cyc();
    ifc.run = 1'b0; ifc.dir = 1'b1; ifc.brightness = 8'd127;
    rst_n = 1'b1;
    model_reset();
    restart_tracking();
    repeat (4) cyc();
    act = 0;
    repeat (20) begin cyc(); if (ifc.pwm_out[1] === 1'b0) act++; end
    chk("bright127_active", act, 10);
    ifc.brightness = 8'd0;
    repeat (3) cyc();
    act = 0;
    repeat (20) begin cyc(); if (ifc.pwm_out[1] === 1'b0) act++; end
    chk("bright0_active", act, 0);
    ifc.brightness = 8'd255;
    repeat (3) cyc();
    act = 0;
    repeat (20) begin cyc(); if (ifc.pwm_out[1] === 1'b0) act++; end
    chk("bright255_active", act, 20);

    // sync_clr on the tick that would step state 3 -> 4
    ifc.run = 1'b1;
    found = 0;
    for (int k = 0; k < 400; k++) begin
      cyc();
      if (e_tick && e_state == 3 && (m_ticks % TMAX) == TMAX - 1) begin found = 1; break; end
    end
    if (!found) begin
      n_cmp++; n_fail++;
      $error("FAIL sync_setup_timeout: observed no state-3 step tick, expected one within 400 cycles");
    end
    ifc.sync_clr = 1'b1;
    n_wrap = 0;
    cyc();
    ifc.sync_clr = 1'b0;
    chk("sync_state", ifc.state, 0);
    chk("sync_wrap", n_wrap, 0);
    chk("sync_tick", ifc.tick, 0);
    repeat (2) cyc();
    act = 0;
    tog = 0;
    repeat (16) begin
      cyc();
      if (ifc.pwm_out[1] === 1'b0) act++;
      if (ifc.pwm_out[0] === 1'b0) tog++;
    end
    chk("sync_ch1_active", act, 16);
    chk("sync_ch0_active", tog, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
